register_collector: RTL and testbench

- Serial-in, parallel-out frame collector. It is the receive-side counterpart of the register shifter.
- Accepts BITS-wide words one per handshake and packs LENGTH of them into a parallel frame, slot 0 first.
- When the frame is complete, it presents the frame with a valid/ready handshake to the downstream parallel consumer, such as the readout buffer or a comparator stage.

---
 rtl/register_collector.sv | 90 +++++++++
 tb/tb_register_collector.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_collector.sv
// Purpose : collects LENGTH serial BITS-wide words into one parallel frame, slot 0 first.
// Latency : out_valid rises on the same edge that captures the last word of the frame.
// Backpres: in_ready drops while a complete frame waits; the frame is held until out_ready.
//
// Ports:
//   clk, reset      - rising-edge clock, asynchronous active-high reset
//   flush           - synchronous abort of the partial or complete frame
//   in_valid/in_data/in_ready    - serial word handshake (in_ready combinational)
//   out_valid/out_data/out_ready - parallel frame handshake, word k at out_data[k*BITS +: BITS]
//   count           - words stored in the current frame (0..LENGTH)
//   frames          - completed-and-consumed frame counter, wraps 255->0
module register_collector #(
    parameter int BITS   = 4,
    parameter int LENGTH = 4,
    parameter int CW     = $clog2(LENGTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [BITS-1:0]          in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [BITS*LENGTH-1:0]   out_data,
    input  logic                     out_ready,
    output logic [CW-1:0]            count,
    output logic [7:0]               frames
);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t state;

    // Gated by reset so upstream sees "not ready" for the whole reset window,
    // not only after the first clock edge.
    assign in_ready = (state == COLLECT) & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= COLLECT;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            frames    <= '0;
        end else if (flush) begin
            // Flush outranks both handshakes: an incoming word is dropped and a
            // frame being taken this cycle is not counted.
            state     <= COLLECT;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (in_valid) begin
                        // Unwritten slots keep the previous frame's words; only the
                        // slot addressed by count is overwritten.
                        for (int k = 0; k < LENGTH; k++) begin
                            if (count == CW'(k)) begin
                                out_data[k*BITS +: BITS] <= in_data;
                            end
                        end
                        if (count == CW'(LENGTH - 1)) begin
                            state     <= FULL;
                            out_valid <= 1'b1;
                            count     <= CW'(LENGTH);
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state     <= COLLECT;
                        out_valid <= 1'b0;
                        count     <= '0;
                        frames    <= frames + 8'd1;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_register_collector.sv
module tb_register_collector;

    localparam int BITS   = 4;
    localparam int LENGTH = 4;
    localparam int CW     = $clog2(LENGTH + 1);
    localparam int FW     = BITS * LENGTH;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic [BITS-1:0] in_data = '0;
    logic            in_ready;
    logic            out_valid;
    logic [FW-1:0]   out_data;
    logic            out_ready = 1'b0;
    logic [CW-1:0]   count;
    logic [7:0]      frames;

    int tests = 0;
    int fails = 0;

    // Reference model: the words of the current frame in arrival order, plus
    // the consumed-frame tally. A frame is complete when LENGTH words are held.
    logic [BITS-1:0] mq[$];
    int              m_frames = 0;

    always #5 clk = ~clk;

    register_collector #(.BITS(BITS), .LENGTH(LENGTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .frames    (frames)
    );

    function automatic logic [FW-1:0] m_frame();
        logic [FW-1:0] f = '0;
        for (int k = 0; k < mq.size(); k++) f[k*BITS +: BITS] = mq[k];
        return f;
    endfunction

    function automatic bit m_full();
        return mq.size() == LENGTH;
    endfunction

    // Apply inputs, take one rising edge, advance the model, settle 1 time unit.
    task automatic drive(input logic v, input logic [BITS-1:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        if (f) begin
            mq.delete();
        end else if (m_full()) begin
            if (r) begin
                mq.delete();
                m_frames = (m_frames + 1) % 256;
            end
        end else if (v) begin
            mq.push_back(d);
        end
        #1;
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if (count !== 0 || out_valid !== 1'b0 || frames !== 8'd0 || out_data !== '0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: count=%0d out_valid=%b frames=%0d out_data=%h in_ready=%b, want 0/0/0/0/0",
                     count, out_valid, frames, out_data, in_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mq.delete();
        m_frames = 0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        int bad = 0;
        drive(1, 4'h1, 0, 0);
        drive(1, 4'h2, 0, 0);
        drive(1, 4'h3, 0, 0);
        tests++;
        if (out_valid !== 1'b0 || count !== 3) begin
            fails++;
            $display("FAIL basic_three_words: out_valid=%b count=%0d want 0/3", out_valid, count);
        end
        drive(1, 4'h4, 0, 0);
        tests++;
        if (out_valid !== 1'b1 || out_data !== 16'h4321 || count !== 4 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL basic_full: out_valid=%b out_data=%h count=%0d in_ready=%b want 1/4321/4/0",
                     out_valid, out_data, count, in_ready);
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'($urandom), 4'($urandom), 0, 0);
            if (out_valid !== 1'b1 || out_data !== 16'h4321 || count !== 4 || in_ready !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL basic_hold: %0d of 10 cycles lost the held frame, want 0", bad);
        end
        drive(0, 4'h0, 1, 0);
        tests++;
        if (out_valid !== 1'b0 || count !== 0 || frames !== 8'd1 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL basic_consume: out_valid=%b count=%0d frames=%0d in_ready=%b want 0/0/1/1",
                     out_valid, count, frames, in_ready);
        end
        drive(1, 4'hA, 0, 0);
        drive(1, 4'hB, 0, 0);
        drive(1, 4'hC, 0, 0);
        drive(1, 4'hD, 0, 0);
        tests++;
        if (out_valid !== 1'b1 || out_data !== 16'hDCBA || out_data !== m_frame()) begin
            fails++;
            $display("FAIL basic_second_frame: out_valid=%b out_data=%h want 1/dcba", out_valid, out_data);
        end
        drive(0, 4'h0, 1, 0);
    endtask

    task automatic test_gapped();
        logic [BITS-1:0] dat[8] = '{4'h5, 4'h0, 4'h0, 4'h0, 4'h6, 4'h0, 4'h7, 4'h8};
        logic            vld[8] = '{1, 0, 0, 0, 1, 0, 1, 1};
        int              exp_cnt[7] = '{1, 1, 1, 1, 2, 2, 3};
        for (int i = 0; i < 7; i++) begin
            drive(vld[i], dat[i], 0, 0);
            tests++;
            if (count !== CW'(exp_cnt[i]) || out_valid !== 1'b0) begin
                fails++;
                $display("FAIL gapped_count[%0d]: count=%0d out_valid=%b want %0d/0", i, count, out_valid, exp_cnt[i]);
            end
        end
        drive(vld[7], dat[7], 0, 0);
        tests++;
        if (out_valid !== 1'b1 || out_data !== 16'h8765) begin
            fails++;
            $display("FAIL gapped_frame: out_valid=%b out_data=%h want 1/8765", out_valid, out_data);
        end
        drive(0, 4'h0, 1, 0);
    endtask

    task automatic test_flush();
        logic [7:0] fr_before;
        drive(1, 4'h1, 0, 0);
        drive(1, 4'h2, 0, 0);
        drive(1, 4'h3, 0, 1);
        tests++;
        if (count !== 0 || out_data !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_partial: count=%0d out_data=%h out_valid=%b in_ready=%b want 0/0000/0/1",
                     count, out_data, out_valid, in_ready);
        end
        drive(1, 4'h9, 0, 0);
        drive(1, 4'h8, 0, 0);
        drive(1, 4'h7, 0, 0);
        drive(1, 4'h6, 0, 0);
        tests++;
        if (out_valid !== 1'b1 || out_data !== 16'h6789) begin
            fails++;
            $display("FAIL flush_next_frame: out_valid=%b out_data=%h want 1/6789", out_valid, out_data);
        end
        fr_before = frames;
        drive(0, 4'h0, 1, 1);
        tests++;
        if (out_valid !== 1'b0 || count !== 0 || frames !== fr_before || frames !== 8'(m_frames)) begin
            fails++;
            $display("FAIL flush_full_with_ready: out_valid=%b count=%0d frames=%0d want 0/0/%0d",
                     out_valid, count, frames, fr_before);
        end
    endtask

    task automatic test_async_reset();
        drive(1, 4'h1, 0, 0);
        drive(1, 4'h2, 0, 0);
        drive(1, 4'h3, 0, 0);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        mq.delete();
        m_frames = 0;
        #1;
        tests++;
        if (count !== 0 || out_valid !== 1'b0 || in_ready !== 1'b0 || frames !== 8'd0) begin
            fails++;
            $display("FAIL async_reset: count=%0d out_valid=%b in_ready=%b frames=%0d want 0/0/0/0",
                     count, out_valid, in_ready, frames);
        end
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        drive(1, 4'hE, 0, 0);
        drive(1, 4'hF, 0, 0);
        drive(1, 4'h0, 0, 0);
        drive(1, 4'h1, 0, 0);
        tests++;
        if (out_valid !== 1'b1 || out_data !== 16'h10FE || frames !== 8'd0) begin
            fails++;
            $display("FAIL async_reset_recover: out_valid=%b out_data=%h frames=%0d want 1/10fe/0",
                     out_valid, out_data, frames);
        end
        drive(0, 4'h0, 1, 0);
    endtask

    task automatic test_wrap();
        int bad = 0;
        int pulses = 0;
        reset = 1'b1;
        #1 reset = 1'b0;
        mq.delete();
        m_frames = 0;
        for (int i = 0; i < 256 * 5; i++) begin
            drive(1, 4'($urandom), 1, 0);
            if (out_valid) pulses++;
            if (out_valid !== ((i % 5) == 3)) bad++;
        end
        tests++;
        if (bad != 0 || pulses != 256) begin
            fails++;
            $display("FAIL wrap_cadence: %0d off-pattern cycles, %0d pulses, want 0/256", bad, pulses);
        end
        tests++;
        if (frames !== 8'd0 || frames !== 8'(m_frames)) begin
            fails++;
            $display("FAIL wrap_frames: frames=%0d want 0", frames);
        end
    endtask

    task automatic test_random();
        logic v, r, f;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 9) < 6);
            f = ($urandom_range(0, 19) == 0);
            drive(v, 4'($urandom), r, f);
            tests++;
            if (count !== CW'(mq.size()) || out_valid !== m_full() || in_ready !== !m_full()
                || frames !== 8'(m_frames) || (m_full() && out_data !== m_frame())) begin
                fails++;
                $display("FAIL random[%0d]: count=%0d out_valid=%b in_ready=%b frames=%0d out_data=%h want %0d/%b/%b/%0d/%h",
                         i, count, out_valid, in_ready, frames, out_data,
                         mq.size(), m_full(), !m_full(), m_frames, m_frame());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_flush();
        test_async_reset();
        test_random();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
